// File: rtl/axi_write_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Package : common_defs
// Brief   : Shared types and AXI constants for the posted-write buffer.
// Rev     : 1.0 - initial release
// ============================================================================
package common_defs;

    localparam int BLOCK_WIDTH = 128;
    localparam int WORD_WIDTH  = 32;
    localparam int ADDR_WIDTH  = 32;

    localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [7:0] AXI_LEN_BLOCK  = 8'd3;
    localparam logic [7:0] AXI_LEN_WORD   = 8'd0;

    typedef struct packed {
        logic                   is_block;
        logic [ADDR_WIDTH-1:0]  addr;
        logic [BLOCK_WIDTH-1:0] data;
        logic [3:0]             strb;
    } wbuf_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AW   = 2'd1,
        W    = 2'd2,
        B    = 2'd3
    } wbuf_state_t;

    // Word idx of a block, word0 in the least significant lane.
    function automatic logic [WORD_WIDTH-1:0] block_word(
        input logic [BLOCK_WIDTH-1:0] data,
        input logic [1:0]             idx
    );
        return data[WORD_WIDTH*idx +: WORD_WIDTH];
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_write_buffer_wbuf_store.sv
`default_nettype none
// ============================================================================
// Module : wbuf_store
// Brief  : Circular entry FIFO with head/tail/count and read-address matching.
// Rev    : 1.0 - initial release
// ============================================================================
module wbuf_store
    import common_defs::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     i_push,
    input  wbuf_entry_t              i_entry,
    input  logic                     i_pop,
    input  logic [27:0]              i_lookup_tag,
    output wbuf_entry_t              o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_conflict
);

    localparam int PTR_W = $clog2(DEPTH);

    wbuf_entry_t        r_mem [DEPTH];
    logic [DEPTH-1:0]   r_valid;
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [PTR_W:0]     r_count;
    logic [DEPTH-1:0]   w_hit;

    // Payload storage carries no reset; r_valid qualifies every use of it.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_tail] <= i_entry;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            if (i_push) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
            assign w_hit[gi] = r_valid[gi] && (r_mem[gi].addr[31:4] == i_lookup_tag);
        end
    endgenerate

    assign o_conflict = |w_hit;
    assign o_head     = r_mem[r_head];
    assign o_count    = r_count;

endmodule
`default_nettype wire

// File: rtl/axi_write_buffer.sv
`default_nettype none
// ============================================================================
// Module : axi_write_buffer
// Brief  : Posted-write buffer draining cache evictions/stores to AXI AW/W/B.
// Rev    : 1.0 - initial release
// ============================================================================
module axi_write_buffer
    import common_defs::*;
#(
    parameter int         DEPTH   = 4,
    parameter logic [3:0] AXI_WID = 4'd1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         wb_valid,
    output logic         wb_ready,
    input  logic         wb_is_block,
    input  logic [31:0]  wb_addr,
    input  logic [127:0] wb_block,
    input  logic [31:0]  wb_word,
    input  logic [3:0]   wb_strb,
    input  logic [31:0]  lookup_addr,
    output logic         lookup_conflict,
    output logic         empty,
    output logic [3:0]   awid,
    output logic [31:0]  awaddr,
    output logic [7:0]   awlen,
    output logic [2:0]   awsize,
    output logic [1:0]   awburst,
    output logic [1:0]   awlock,
    output logic [3:0]   awcache,
    output logic [2:0]   awprot,
    output logic         awvalid,
    input  logic         awready,
    output logic [3:0]   wid,
    output logic [31:0]  wdata,
    output logic [3:0]   wstrb,
    output logic         wlast,
    output logic         wvalid,
    input  logic         wready,
    input  logic [3:0]   bid,
    input  logic [1:0]   bresp,
    input  logic         bvalid,
    output logic         bready
);

    localparam int                CNT_W  = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0]  C_FULL = CNT_W'(DEPTH);

    wbuf_state_t        r_state;
    wbuf_state_t        w_state_next;
    logic [1:0]         r_beat;
    logic [1:0]         w_beat_next;
    logic               w_push;
    logic               w_pop;
    logic               w_last;
    logic [7:0]         w_len;
    logic [CNT_W-1:0]   w_count;
    logic               w_conflict;
    wbuf_entry_t        w_entry;
    wbuf_entry_t        w_head;
    logic               w_unused;

    assign w_unused = ^{bid, bresp, lookup_addr[3:0]};

    // Word stores keep their data in lane 0 so beat 0 selects it like a block.
    always_comb begin
        w_entry          = '0;
        w_entry.is_block = wb_is_block;
        w_entry.addr     = wb_addr;
        w_entry.data     = wb_is_block ? wb_block : {96'b0, wb_word};
        w_entry.strb     = wb_is_block ? 4'hf : wb_strb;
    end

    assign wb_ready = (w_count != C_FULL);
    assign w_push   = wb_valid && wb_ready;

    wbuf_store #(
        .DEPTH (DEPTH)
    ) u_store (
        .clk          (clk),
        .rstn         (rstn),
        .i_push       (w_push),
        .i_entry      (w_entry),
        .i_pop        (w_pop),
        .i_lookup_tag (lookup_addr[31:4]),
        .o_head       (w_head),
        .o_count      (w_count),
        .o_conflict   (w_conflict)
    );

    assign w_len  = w_head.is_block ? AXI_LEN_BLOCK : AXI_LEN_WORD;
    assign w_last = (r_beat == w_len[1:0]);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_beat  <= 2'd0;
        end else begin
            r_state <= w_state_next;
            r_beat  <= w_beat_next;
        end
    end

    // Leaving IDLE on the accepting edge puts awvalid up the cycle after a push.
    always_comb begin
        w_state_next = r_state;
        w_beat_next  = r_beat;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                if ((w_count != '0) || w_push) begin
                    w_state_next = AW;
                end
            end
            AW: begin
                if (awready) begin
                    w_state_next = W;
                    w_beat_next  = 2'd0;
                end
            end
            W: begin
                if (wready) begin
                    if (w_last) begin
                        w_state_next = B;
                    end else begin
                        w_beat_next = r_beat + 2'd1;
                    end
                end
            end
            B: begin
                if (bvalid) begin
                    w_pop        = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign awid    = AXI_WID;
    assign awaddr  = w_head.addr;
    assign awlen   = w_len;
    assign awsize  = AXI_SIZE_WORD;
    assign awburst = AXI_BURST_INCR;
    assign awlock  = 2'b00;
    assign awcache = 4'h0;
    assign awprot  = 3'h0;
    assign awvalid = (r_state == AW);

    assign wid    = AXI_WID;
    assign wdata  = block_word(w_head.data, r_beat);
    assign wstrb  = w_head.strb;
    assign wvalid = (r_state == W);
    assign wlast  = wvalid && w_last;

    assign bready = (r_state == B);

    assign lookup_conflict = w_conflict;
    assign empty           = (w_count == '0) && (r_state == IDLE);

endmodule
`default_nettype wire

// File: tb/tb_axi_write_buffer.sv
`default_nettype none
// ============================================================================
// Module : tb_axi_write_buffer
// Brief  : Directed and randomized bench for axi_write_buffer with a queue model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_axi_write_buffer;

    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rstn;
    logic         wb_valid, wb_ready, wb_is_block;
    logic [31:0]  wb_addr, wb_word, lookup_addr;
    logic [127:0] wb_block;
    logic [3:0]   wb_strb;
    logic         lookup_conflict, empty;
    logic [3:0]   awid, awcache, wid, wstrb, bid;
    logic [31:0]  awaddr, wdata;
    logic [7:0]   awlen;
    logic [2:0]   awsize, awprot;
    logic [1:0]   awburst, awlock, bresp;
    logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    always #5 clk = ~clk;

    axi_write_buffer #(.DEPTH(DEPTH), .AXI_WID(4'd1)) dut (
        .clk(clk), .rstn(rstn),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_is_block(wb_is_block),
        .wb_addr(wb_addr), .wb_block(wb_block), .wb_word(wb_word), .wb_strb(wb_strb),
        .lookup_addr(lookup_addr), .lookup_conflict(lookup_conflict), .empty(empty),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid),
        .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    typedef struct {
        bit         blk;
        bit [31:0]  addr;
        bit [127:0] data;
        bit [3:0]   strb;
    } ent_t;

    ent_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          slave_mode;
    bit          b_pending;
    int          b_delay;
    bit          txn_aw, txn_wdone;
    int          txn_beat;
    bit          aw_hold, w_hold;
    logic [39:0] aw_prev;
    logic [36:0] w_prev;
    bit          saw_last, saw_b;
    bit          found;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_conflict(input logic [31:0] la);
        foreach (q[i]) if (q[i].addr[31:4] == la[31:4]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        q.delete();
        txn_aw = 0; txn_wdone = 0; txn_beat = 0;
        aw_hold = 0; w_hold = 0; b_pending = 0; b_delay = 0;
        saw_last = 0; saw_b = 0;
        bvalid = 1'b0;
    endtask

    // Observes the current cycle, checks it against the queue model, then
    // applies the pop/push that the coming edge performs.
    task automatic monitor();
        ent_t e;
        bit   push_ok;
        int   maxb;
        push_ok = rstn && wb_valid && (q.size() != DEPTH);
        chk("wb_ready", wb_ready, q.size() != DEPTH);
        chk("empty", empty, q.size() == 0);
        chk("conflict", lookup_conflict, model_conflict(lookup_addr));
        if (wvalid) chk("wvalid_after_aw", {txn_aw, txn_wdone}, 2'b10);
        if (bready) chk("bready_after_w", txn_wdone, 1'b1);
        if (aw_hold) chk("aw_stable", {awvalid, awaddr, awlen}, {1'b1, aw_prev});
        if (w_hold)  chk("w_stable", {wvalid, wdata, wstrb, wlast}, {1'b1, w_prev});
        aw_hold = awvalid && !awready;
        aw_prev = {awaddr, awlen};
        w_hold  = wvalid && !wready;
        w_prev  = {wdata, wstrb, wlast};
        saw_last = 0;
        saw_b    = 0;
        if (awvalid && awready) begin
            chk("aw_order", {txn_aw, q.size() != 0}, 2'b01);
            if (q.size() != 0) begin
                e = q[0];
                chk("awaddr", awaddr, e.addr);
                chk("awlen", awlen, e.blk ? 8'd3 : 8'd0);
                chk("aw_fixed", {awid, awsize, awburst, awlock, awcache, awprot},
                    {4'd1, 3'b010, 2'b01, 2'b00, 4'h0, 3'h0});
            end
            txn_aw   = 1;
            txn_beat = 0;
        end
        if (wvalid && wready && q.size() != 0) begin
            e    = q[0];
            maxb = e.blk ? 3 : 0;
            chk("wdata", wdata, 32'(e.data >> (32 * txn_beat)));
            chk("wstrb", wstrb, e.blk ? 4'hf : e.strb);
            chk("wlast", wlast, txn_beat == maxb);
            chk("wid", wid, 4'd1);
            if (txn_beat == maxb) begin
                txn_wdone = 1;
                saw_last  = 1;
            end
            txn_beat++;
        end
        if (bvalid && bready) begin
            chk("b_after_last", txn_wdone, 1'b1);
            saw_b = 1;
            if (q.size() != 0) void'(q.pop_front());
            txn_aw    = 0;
            txn_wdone = 0;
        end
        if (push_ok) begin
            e.blk  = wb_is_block;
            e.addr = wb_addr;
            e.data = wb_is_block ? wb_block : {96'b0, wb_word};
            e.strb = wb_strb;
            q.push_back(e);
        end
    endtask

    task automatic slave_drive();
        case (slave_mode)
            0: begin awready = 1'b1; wready = 1'b1; end
            1: begin awready = 1'b0; wready = 1'b1; end
            default: begin
                awready = 1'($urandom_range(0, 1));
                wready  = 1'($urandom_range(0, 1));
            end
        endcase
        if (saw_b) bvalid = 1'b0;
        if (saw_last) begin
            b_pending = 1;
            b_delay   = (slave_mode == 2) ? int'($urandom_range(0, 3)) : 0;
        end
        if (b_pending && !bvalid) begin
            if (b_delay == 0) begin
                bvalid    = 1'b1;
                b_pending = 0;
            end else begin
                b_delay--;
            end
        end
    endtask

    task automatic step();
        #1;
        monitor();
        @(posedge clk);
        #1;
        slave_drive();
    endtask

    task automatic drain(input int budget);
        wb_valid = 1'b0;
        for (int k = 0; k < budget && q.size() != 0; k++) step();
        chk("drain_done", q.size(), 0);
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        wb_valid = 0; wb_is_block = 0; wb_addr = 0; wb_block = 0; wb_word = 0; wb_strb = 0;
        lookup_addr = 0; awready = 0; wready = 0; bid = 4'd0; bresp = 2'b00;
        slave_mode = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outputs", {wb_ready, empty, lookup_conflict, awvalid, wvalid, bready, wlast},
            7'b1100000);
        rstn = 1'b1;
        slave_drive();
        step();

        // Single block with all readies high, lookup hitting the same line.
        lookup_addr = 32'h1C00_001C;
        wb_valid = 1; wb_is_block = 1; wb_addr = 32'h1C00_0010;
        wb_block = {32'h44, 32'h33, 32'h22, 32'h11};
        #1 chk("t1_conflict_before", lookup_conflict, 1'b0);
        step();
        wb_valid = 0;
        for (int c = 1; c <= 7; c++) begin
            #1;
            chk("t1_awvalid", awvalid, c == 1);
            chk("t1_wvalid", wvalid, (c >= 2) && (c <= 5));
            if (c >= 2 && c <= 5) chk("t1_wdata", wdata, 32'h11 * (c - 1));
            chk("t1_wlast", wlast, c == 5);
            chk("t1_bready", bready, c == 6);
            chk("t1_conflict", lookup_conflict, c <= 6);
            chk("t1_empty", empty, c == 7);
            step();
        end

        // Uncached single-word store.
        lookup_addr = 32'h0;
        wb_valid = 1; wb_is_block = 0; wb_addr = 32'hBFAF_8004;
        wb_word = 32'hDEAD_BEEF; wb_strb = 4'b0011;
        step();
        wb_valid = 0;
        for (int c = 1; c <= 4; c++) begin
            #1;
            chk("t2_awvalid", awvalid, c == 1);
            if (c == 1) chk("t2_awlen", awlen, 8'd0);
            chk("t2_wvalid", wvalid, c == 2);
            chk("t2_wlast", wlast, c == 2);
            if (c == 2) chk("t2_w", {wdata, wstrb}, {32'hDEAD_BEEF, 4'b0011});
            chk("t2_bready", bready, c == 3);
            chk("t2_empty", empty, c == 4);
            step();
        end

        // Fill while AW is stalled, then release with a push colliding with the pop.
        slave_mode = 1;
        awready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wb_valid = 1; wb_is_block = 1; wb_addr = 32'h2000_0000 + 32'(i * 64);
            wb_block = {$urandom, $urandom, $urandom, $urandom};
            #1 chk("t3_ready_fill", wb_ready, 1'b1);
            step();
        end
        wb_is_block = 0; wb_addr = 32'h3000_0008; wb_word = $urandom; wb_strb = 4'b1100;
        slave_mode = 0;
        awready = 1'b1;
        #1;
        chk("t3_full", wb_ready, 1'b0);
        chk("t3_aw_stalled", awvalid, 1'b1);
        step();
        found = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (bvalid && bready) begin
                found = 1;
                break;
            end
            step();
        end
        chk("t3_pop_seen", found, 1'b1);
        chk("t3_refused_on_pop", wb_ready, 1'b0);
        step();
        #1 chk("t3_ready_after_pop", wb_ready, 1'b1);
        step();
        wb_valid = 0;
        #1 chk("t3_full_again", wb_ready, 1'b0);
        drain(200);

        // Reset in the middle of the W phase.
        lookup_addr = 32'h5000_0004;
        wb_valid = 1; wb_is_block = 1; wb_addr = 32'h5000_0000;
        wb_block = {$urandom, $urandom, $urandom, $urandom};
        step();
        wb_valid = 0;
        step();
        step();
        #1 chk("t4_in_w", wvalid, 1'b1);
        rstn = 1'b0;
        #1;
        chk("t4_rst_outputs",
            {wb_ready, empty, lookup_conflict, awvalid, wvalid, bready, wlast}, 7'b1100000);
        model_reset();
        step();
        rstn = 1'b1;
        step();
        wb_valid = 1; wb_is_block = 0; wb_addr = 32'h6000_0000; wb_word = $urandom; wb_strb = 4'hf;
        step();
        wb_valid = 0;
        #1 chk("t4_restart_aw", awvalid, 1'b1);
        drain(50);

        // Random traffic with random AXI stalls.
        slave_mode = 2;
        for (int n = 0; n < 800; n++) begin
            wb_valid    = ($urandom_range(0, 2) != 0);
            wb_is_block = 1'($urandom_range(0, 1));
            wb_addr     = 32'h8000_0000 | (32'($urandom_range(0, 7)) << 4) |
                          (wb_is_block ? 32'h0 : (32'($urandom_range(0, 3)) << 2));
            wb_block    = {$urandom, $urandom, $urandom, $urandom};
            wb_word     = $urandom;
            wb_strb     = 4'($urandom_range(1, 15));
            lookup_addr = ($urandom_range(0, 1) != 0) ?
                          (32'h8000_0000 | (32'($urandom_range(0, 15)) << 4) | 32'($urandom_range(0, 15))) :
                          32'($urandom);
            step();
        end
        drain(4000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
